// File: rtl/derivative.sv
// Backward first difference of an unsigned sample stream, scaled by 2^GAIN_SHIFT
// and saturated into a signed output register (one clock of latency).
module derivative #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int GAIN_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic [IN_W-1:0]   In,
    output logic [OUT_W-1:0]  d_in
);

    localparam int SW = IN_W + 1 + GAIN_SHIFT;
    localparam int CW = (SW > OUT_W) ? SW : OUT_W;

    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [IN_W-1:0]        prev_reg;
    logic                   primed_reg;
    logic [OUT_W-1:0]       d_in_reg;

    logic signed [IN_W:0]   diff;
    logic signed [CW-1:0]   scaled;
    logic [OUT_W-1:0]       sat_val;
    logic [OUT_W-1:0]       d_in_next;

    assign diff   = $signed({1'b0, In}) - $signed({1'b0, prev_reg});
    // Working width covers the full shifted range, so the shift never overflows.
    assign scaled = CW'(diff) <<< GAIN_SHIFT;

    always_comb begin
        sat_val = scaled[OUT_W-1:0];
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
    end

    // First capture after reset reports zero instead of a step against prev=0.
    assign d_in_next = primed_reg ? sat_val : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_reg   <= '0;
            primed_reg <= 1'b0;
            d_in_reg   <= '0;
        end else if (enb) begin
            prev_reg   <= In;
            primed_reg <= 1'b1;
            d_in_reg   <= d_in_next;
        end
    end

    assign d_in = d_in_reg;

endmodule

// File: tb/tb_derivative.sv
// Self-checking bench for derivative: directed scenarios plus randomized stream
// against an integer-arithmetic model, on GAIN_SHIFT=0 and GAIN_SHIFT=2 instances.
module tb_derivative;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic [7:0] In;
    logic [7:0] d_in;
    logic [7:0] d_in_g2;

    int checks = 0;
    int passed = 0;

    // Reference model state (plain integers)
    int  m_prev;
    bit  m_primed;
    int  m_d0;
    int  m_d2;

    always #5 clk = ~clk;

    derivative #(.IN_W(8), .OUT_W(8), .GAIN_SHIFT(0)) dut (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .In    (In),
        .d_in  (d_in)
    );

    derivative #(.IN_W(8), .OUT_W(8), .GAIN_SHIFT(2)) dut_g2 (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .In    (In),
        .d_in  (d_in_g2)
    );

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_clear();
        m_prev   = 0;
        m_primed = 1'b0;
        m_d0     = 0;
        m_d2     = 0;
    endtask

    task automatic step(input string tag, input logic en, input logic [7:0] v);
        int d;
        enb = en;
        In  = v;
        @(posedge clk);
        if (reset && en) begin
            if (!m_primed) begin
                m_d0     = 0;
                m_d2     = 0;
                m_primed = 1'b1;
            end else begin
                d    = int'(v) - m_prev;
                m_d0 = sat8(d);
                m_d2 = sat8(d * 4);
            end
            m_prev = int'(v);
        end
        #1;
        $display("%s: rst=%0b enb=%0b In=%0d d_in=%0d d_in_g2=%0d", tag, reset, en, v, s8(d_in), s8(d_in_g2));
        check({tag, "_g0"}, s8(d_in), m_d0);
        check({tag, "_g2"}, s8(d_in_g2), m_d2);
    endtask

    // Asynchronous assert away from any edge, verify clear before the next edge, release mid-cycle
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        model_clear();
        check({tag, "_async_g0"}, s8(d_in), 0);
        check({tag, "_async_g2"}, s8(d_in_g2), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        enb   = 1'b0;
        In    = 8'h00;
        model_clear();
        #2;
        check("por_g0", s8(d_in), 0);
        check("por_g2", s8(d_in_g2), 0);

        // Reset held: enb and In ignored across edges
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 8'h55);
        @(negedge clk);
        reset = 1'b1;

        // Ramp slope 1, then hold
        for (int i = 0; i <= 4; i++) step("ramp1", 1'b1, 8'(i));
        check("ramp1_last", s8(d_in), 1);
        step("hold", 1'b1, 8'd4);
        check("hold_zero", s8(d_in), 0);
        step("hold", 1'b1, 8'd4);

        // Ramp slope 2 then step down
        pulse_reset("r2");
        step("ramp2", 1'b1, 8'd0);
        check("ramp2_prime", s8(d_in), 0);
        step("ramp2", 1'b1, 8'd2);
        step("ramp2", 1'b1, 8'd4);
        check("ramp2_slope", s8(d_in), 2);
        step("ramp2", 1'b1, 8'd0);
        check("stepdown", s8(d_in), -4);

        // Saturation both directions
        pulse_reset("sat");
        step("sat", 1'b1, 8'd0);
        step("sat", 1'b1, 8'd255);
        check("sat_pos", s8(d_in), 127);
        step("sat", 1'b1, 8'd0);
        check("sat_neg", s8(d_in), -128);
        pulse_reset("satg");
        step("satg", 1'b1, 8'd10);
        step("satg", 1'b1, 8'd50);
        check("sat_gain2", s8(d_in_g2), 127);
        check("nosat_gain0", s8(d_in), 40);

        // Enable gating
        pulse_reset("gate");
        step("gate", 1'b1, 8'd10);
        step("gate", 1'b1, 8'd10);
        step("gate", 1'b0, 8'd20);
        step("gate", 1'b0, 8'd30);
        step("gate", 1'b0, 8'd40);
        check("gate_hold", s8(d_in), 0);
        step("gate", 1'b1, 8'd40);
        check("gate_resume", s8(d_in), 30);

        // Reset mid-stream
        pulse_reset("mid");
        step("mid", 1'b1, 8'd0);
        step("mid", 1'b1, 8'd1);
        check("mid_run", s8(d_in), 1);
        pulse_reset("mid2");
        step("mid", 1'b1, 8'd100);
        check("mid_prime", s8(d_in), 0);
        step("mid", 1'b1, 8'd101);
        check("mid_diff", s8(d_in), 1);

        // Randomized stream with occasional resets and enable gaps
        for (int i = 0; i < 300; i++) begin
            logic       en;
            logic [7:0] v;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) v = 8'($urandom_range(0, 255));
            else v = 8'(m_prev + int'($urandom_range(0, 8)) - 4);
            if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
            step("rnd", en, v);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
